// File: rtl/disp_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : disp_scan_ctrl
// Purpose  : Display controller for the ALU result path. Accepts an 8-bit
//            unsigned result and a 4-bit letter code over valid/ready. The
//            result is converted to three BCD digits with an iterative
//            shift-add-3 (double dabble) sequencer. The digits are committed
//            atomically to a display buffer. The four 7-segment anodes are
//            time-multiplexed at a rate of DIV clocks per digit slot.
// Ports    : Clk        - system clock, rising edge
//            Reset      - asynchronous, active-low reset
//            in_valid   - in_data/in_letter valid
//            in_ready   - block can accept a value (IDLE only)
//            in_data    - unsigned result, 0..255
//            in_letter  - code shown on the fourth digit
//            letter_en  - 1 = show letter digit, 0 = blank it (live)
//            blank_lz   - 1 = blank leading zeros of hundreds/tens (live)
//            busy       - conversion in progress (CONV or COMMIT)
//            AN         - anode enables, active-low
//            digit      - decoder code for the enabled slot
// Revision : 1.0 - initial release
// ============================================================================
module disp_scan_ctrl #(
    parameter int DIV = 50000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic [3:0] in_letter,
    input  logic       letter_en,
    input  logic       blank_lz,
    output logic       busy,
    output logic [3:0] AN,
    output logic [3:0] digit
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_CONV   = 2'd1;
    localparam logic [1:0] c_ST_COMMIT = 2'd2;

    localparam int              c_PW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_PW-1:0] c_PRESC_MAX = c_PW'(DIV - 1);

    // ------------------------------------------------------------------------
    // Conversion state
    // ------------------------------------------------------------------------
    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [2:0]  r_cnt;
    logic [7:0]  r_shift;
    logic [11:0] r_bcd;
    logic [11:0] w_bcd_adj;
    logic [3:0]  r_letter_hold;

    // Display buffer, only ever written in COMMIT
    logic [3:0]  r_ones;
    logic [3:0]  r_tens;
    logic [3:0]  r_hund;
    logic [3:0]  r_letter;

    // Scan state
    logic [c_PW-1:0] r_presc;
    logic [1:0]      r_sel;
    logic            w_tick;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state and handshake outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = c_ST_CONV;
                end
            end
            c_ST_CONV: begin
                // cnt==7 is the eighth and final shift
                if (r_cnt == 3'd7) begin
                    w_state_nxt = c_ST_COMMIT;
                end
            end
            c_ST_COMMIT: begin
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    assign busy = ~in_ready;

    // ------------------------------------------------------------------------
    // Double-dabble correction: each BCD nibble >= 5 gets +3 before the shift
    // so that it carries correctly into the next decade.
    // ------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dd_adj
            assign w_bcd_adj[4*gi +: 4] = (r_bcd[4*gi +: 4] >= 4'd5) ?
                                          (r_bcd[4*gi +: 4] + 4'd3) :
                                          r_bcd[4*gi +: 4];
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Conversion datapath and display buffer
    // ------------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_cnt         <= 3'd0;
            r_shift       <= 8'd0;
            r_bcd         <= 12'd0;
            r_letter_hold <= 4'd0;
            r_ones        <= 4'd0;
            r_tens        <= 4'd0;
            r_hund        <= 4'd0;
            r_letter      <= 4'd0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (in_valid) begin
                        r_shift       <= in_data;
                        r_letter_hold <= in_letter;
                        r_bcd         <= 12'd0;
                        r_cnt         <= 3'd0;
                    end
                end
                c_ST_CONV: begin
                    {r_bcd, r_shift} <= {w_bcd_adj, r_shift} << 1;
                    r_cnt            <= r_cnt + 3'd1;
                end
                c_ST_COMMIT: begin
                    r_ones   <= r_bcd[3:0];
                    r_tens   <= r_bcd[7:4];
                    r_hund   <= r_bcd[11:8];
                    r_letter <= r_letter_hold;
                end
                default: begin
                    r_cnt <= 3'd0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Refresh prescaler and slot select; independent of the conversion FSM
    // ------------------------------------------------------------------------
    assign w_tick = (r_presc == c_PRESC_MAX);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_presc <= '0;
            r_sel   <= 2'd0;
        end else begin
            if (w_tick) begin
                r_presc <= '0;
                r_sel   <= r_sel + 2'd1;
            end else begin
                r_presc <= r_presc + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Slot mapping with live blanking; a blanked slot is AN=1111, digit=0
    // ------------------------------------------------------------------------
    always_comb begin
        AN    = 4'b1111;
        digit = 4'd0;
        case (r_sel)
            2'd0: begin
                AN    = 4'b1110;
                digit = r_ones;
            end
            2'd1: begin
                if (!(blank_lz && (r_hund == 4'd0) && (r_tens == 4'd0))) begin
                    AN    = 4'b1101;
                    digit = r_tens;
                end
            end
            2'd2: begin
                if (!(blank_lz && (r_hund == 4'd0))) begin
                    AN    = 4'b1011;
                    digit = r_hund;
                end
            end
            default: begin
                if (letter_en) begin
                    AN    = 4'b0111;
                    digit = r_letter;
                end
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_disp_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_disp_scan_ctrl
// Purpose  : Self-checking bench for disp_scan_ctrl. Two instances share the
//            inputs: DIV=1 (display contents, scoreboarded) and DIV=4
//            (refresh cadence). Expected slot contents are pushed when a
//            value is offered and checked by a monitor after each commit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_disp_scan_ctrl;

    logic       Clk       = 1'b0;
    logic       Reset     = 1'b0;
    logic       in_valid  = 1'b0;
    logic [7:0] in_data   = 8'd0;
    logic [3:0] in_letter = 4'd0;
    logic       letter_en = 1'b1;
    logic       blank_lz  = 1'b0;

    logic       in_ready, busy;
    logic [3:0] AN, digit;
    logic       in_ready4, busy4;
    logic [3:0] AN4, digit4;

    disp_scan_ctrl #(.DIV(1)) dut (
        .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_letter(in_letter), .letter_en(letter_en),
        .blank_lz(blank_lz), .busy(busy), .AN(AN), .digit(digit)
    );

    disp_scan_ctrl #(.DIV(4)) dut4 (
        .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready4),
        .in_data(in_data), .in_letter(in_letter), .letter_en(letter_en),
        .blank_lz(blank_lz), .busy(busy4), .AN(AN4), .digit(digit4)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;

    // Slot i of a packed record lives in bits [8*i +: 8] as {AN, digit}
    logic [31:0] sb_q[$];
    logic [31:0] cur       = 32'd0;
    int          remaining = 0;
    logic        prev_busy = 1'b0;
    logic [1:0]  m_sel;

    function automatic logic [31:0] exp_slots(input logic [3:0] o, input logic [3:0] t,
                                              input logic [3:0] h, input logic [3:0] l,
                                              input logic len, input logic blz);
        logic [7:0] s0, s1, s2, s3;
        s0 = {4'b1110, o};
        s1 = (blz && h == 4'd0 && t == 4'd0) ? 8'hF0 : {4'b1101, t};
        s2 = (blz && h == 4'd0) ? 8'hF0 : {4'b1011, h};
        s3 = len ? {4'b0111, l} : 8'hF0;
        return {s3, s2, s1, s0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Slot-select model for the DIV=1 instance: advances every cycle
    always @(posedge Clk or negedge Reset) begin
        if (!Reset) m_sel <= 2'd0;
        else        m_sel <= m_sel + 2'd1;
    end

    // Monitor: a busy->idle transition presents a committed value; check the
    // four slots over the next four cycles against the scoreboard entry.
    always @(negedge Clk) begin
        if (!Reset) begin
            prev_busy = 1'b0;
            remaining = 0;
        end else begin
            if (prev_busy && !busy) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_commit: got commit expected none");
                end else begin
                    cur       = sb_q.pop_front();
                    remaining = 4;
                end
            end
            if (remaining > 0) begin
                chk($sformatf("slot%0d", m_sel), {24'd0, AN, digit}, {24'd0, cur[8*m_sel +: 8]});
                remaining--;
            end
            prev_busy = busy;
        end
    end

    task automatic offer(input logic [7:0] d, input logic [3:0] l, input logic [3:0] o,
                         input logic [3:0] t, input logic [3:0] h, input bit push,
                         output int waits);
        in_valid  = 1'b1;
        in_data   = d;
        in_letter = l;
        waits     = 0;
        if (push) sb_q.push_back(exp_slots(o, t, h, l, letter_en, blank_lz));
        while (!in_ready && waits < 50) begin
            @(negedge Clk);
            waits++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1");
        end
        @(posedge Clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((sb_q.size() != 0 || remaining != 0 || busy) && n < 300) begin
            @(negedge Clk);
            n++;
        end
        if (n >= 300) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got pending=%0d expected 0", sb_q.size());
        end
        repeat (2) @(negedge Clk);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int          w;
        logic [15:0] an_tbl;
        logic [31:0] e;
        an_tbl = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

        // Reset state
        #12;
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_an_dig", {24'd0, AN, digit}, {24'd0, 4'b1110, 4'd0});
        chk("rst_an4", {28'd0, AN4}, {28'd0, 4'b1110});
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b1;

        // DIV=4 cadence: slot changes every 4 cycles
        chk("scan4_p0", {28'd0, AN4}, {28'd0, 4'b1110});
        for (int p = 1; p <= 16; p++) begin
            @(negedge Clk);
            chk($sformatf("scan4_p%0d", p), {28'd0, AN4}, {28'd0, an_tbl[4*((p/4)%4) +: 4]});
        end

        // 173 -> 1/7/3, letter A; buffer stays 0 while converting
        offer(8'd173, 4'hA, 4'd3, 4'd7, 4'd1, 1'b1, w);
        for (int i = 0; i <= 8; i++) begin
            @(negedge Clk);
            chk($sformatf("conv_ready_E%0d", i), {31'd0, in_ready}, 32'd0);
            chk($sformatf("conv_buf0_E%0d", i), {28'd0, digit}, 32'd0);
        end
        @(negedge Clk);
        chk("ready_after_E9", {31'd0, in_ready}, 32'd1);
        wait_done();

        offer(8'd255, 4'hC, 4'd5, 4'd5, 4'd2, 1'b1, w);
        wait_done();

        // Leading-zero blanking group
        blank_lz = 1'b1;
        offer(8'd0, 4'hF, 4'd0, 4'd0, 4'd0, 1'b1, w);
        wait_done();
        offer(8'd7, 4'h4, 4'd7, 4'd0, 4'd0, 1'b1, w);
        wait_done();
        offer(8'd105, 4'h6, 4'd5, 4'd0, 4'd1, 1'b1, w);
        wait_done();
        blank_lz = 1'b0;
        @(negedge Clk);

        // Back-to-back: second value accepted exactly at E10
        offer(8'd99, 4'h1, 4'd9, 4'd9, 4'd0, 1'b1, w);
        offer(8'd42, 4'h1, 4'd2, 4'd4, 4'd0, 1'b1, w);
        chk("b2b_accept_E10", w, 10);
        wait_done();

        // Reset at E5 of 200 aborts; buffer returns to 0
        offer(8'd200, 4'h7, 4'd0, 4'd0, 4'd2, 1'b0, w);
        repeat (5) @(negedge Clk);
        Reset = 1'b0;
        #1;
        chk("abort_ready", {31'd0, in_ready}, 32'd1);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_an_dig", {24'd0, AN, digit}, {24'd0, 4'b1110, 4'd0});
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        e = exp_slots(4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            chk($sformatf("abort_slot%0d", m_sel), {24'd0, AN, digit}, {24'd0, e[8*m_sel +: 8]});
        end
        offer(8'd12, 4'h2, 4'd2, 4'd1, 4'd0, 1'b1, w);
        wait_done();

        // DIV=1 with letter disabled: sel3 dark
        letter_en = 1'b0;
        e = exp_slots(4'd2, 4'd1, 4'd0, 4'd2, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            chk($sformatf("noletter_slot%0d", m_sel), {24'd0, AN, digit}, {24'd0, e[8*m_sel +: 8]});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
